// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU sequencer: opcodes, datapath select codes,
// flag bit positions, FSM states and the per-state control word decode.
package cpu_pkg;

  localparam int OPC_W  = 8;
  localparam int FLAG_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA_IMM = 8'h86;
  localparam logic [OPC_W-1:0] OP_LDA_DIR = 8'h87;
  localparam logic [OPC_W-1:0] OP_LDB_IMM = 8'h88;
  localparam logic [OPC_W-1:0] OP_LDB_DIR = 8'h89;
  localparam logic [OPC_W-1:0] OP_STA_DIR = 8'h96;
  localparam logic [OPC_W-1:0] OP_STB_DIR = 8'h97;
  localparam logic [OPC_W-1:0] OP_ADD_AB  = 8'h42;
  localparam logic [OPC_W-1:0] OP_SUB_AB  = 8'h43;
  localparam logic [OPC_W-1:0] OP_AND_AB  = 8'h44;
  localparam logic [OPC_W-1:0] OP_OR_AB   = 8'h45;
  localparam logic [OPC_W-1:0] OP_NOT_A   = 8'h46;
  localparam logic [OPC_W-1:0] OP_BRA     = 8'h20;
  localparam logic [OPC_W-1:0] OP_BMI     = 8'h21;
  localparam logic [OPC_W-1:0] OP_BPL     = 8'h22;
  localparam logic [OPC_W-1:0] OP_BEQ     = 8'h23;
  localparam logic [OPC_W-1:0] OP_BNE     = 8'h24;
  localparam logic [OPC_W-1:0] OP_BVS     = 8'h25;
  localparam logic [OPC_W-1:0] OP_BVC     = 8'h26;
  localparam logic [OPC_W-1:0] OP_BCS     = 8'h27;
  localparam logic [OPC_W-1:0] OP_BCC     = 8'h28;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b111;

  localparam logic [1:0] BUS1_PC = 2'b00;
  localparam logic [1:0] BUS1_A  = 2'b01;
  localparam logic [1:0] BUS1_B  = 2'b10;

  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  typedef enum logic [5:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
    S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
    S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
    S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
    S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
    S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
    S_ADD_4, S_SUB_4, S_AND_4, S_OR_4, S_NOT_4,
    S_BRA_4, S_BRA_5, S_BRA_6,
    S_BNT_4
  } state_t;

  typedef struct packed {
    logic       irLoad;
    logic       marLoad;
    logic       pcLoad;
    logic       pcInc;
    logic       aLoad;
    logic       bLoad;
    logic       ccrLoad;
    logic [2:0] aluSel;
    logic [1:0] bus1Sel;
    logic [1:0] bus2Sel;
    logic       write;
  } ctrl_t;

  // Moore decode: the control word depends on the state alone.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH_0, S_LDA_IMM_4, S_LDA_DIR_4, S_LDB_IMM_4, S_LDB_DIR_4,
      S_STA_DIR_4, S_STB_DIR_4, S_BRA_4: begin
        c.marLoad = 1'b1;
        c.bus1Sel = BUS1_PC;
        c.bus2Sel = BUS2_BUS1;
      end
      S_FETCH_1, S_LDA_IMM_5, S_LDA_DIR_5, S_LDB_IMM_5, S_LDB_DIR_5,
      S_STA_DIR_5, S_STB_DIR_5, S_BNT_4: c.pcInc = 1'b1;
      S_FETCH_2: begin
        c.irLoad  = 1'b1;
        c.bus2Sel = BUS2_MEM;
      end
      S_LDA_IMM_6, S_LDA_DIR_8: begin
        c.aLoad   = 1'b1;
        c.bus2Sel = BUS2_MEM;
      end
      S_LDB_IMM_6, S_LDB_DIR_8: begin
        c.bLoad   = 1'b1;
        c.bus2Sel = BUS2_MEM;
      end
      S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
        c.marLoad = 1'b1;
        c.bus2Sel = BUS2_MEM;
      end
      S_STA_DIR_7: begin
        c.bus1Sel = BUS1_A;
        c.write   = 1'b1;
      end
      S_STB_DIR_7: begin
        c.bus1Sel = BUS1_B;
        c.write   = 1'b1;
      end
      S_ADD_4, S_SUB_4, S_AND_4, S_OR_4, S_NOT_4: begin
        c.bus1Sel = BUS1_A;
        c.bus2Sel = BUS2_ALU;
        c.aLoad   = 1'b1;
        c.ccrLoad = 1'b1;
        case (s)
          S_SUB_4: c.aluSel = ALU_SUB;
          S_AND_4: c.aluSel = ALU_AND;
          S_OR_4:  c.aluSel = ALU_OR;
          S_NOT_4: c.aluSel = ALU_NOT;
          default: c.aluSel = ALU_ADD;
        endcase
      end
      S_BRA_6: begin
        c.pcLoad  = 1'b1;
        c.bus2Sel = BUS2_MEM;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch condition evaluation: decides from the opcode and {N,Z,V,C} flags
// whether a conditional branch is taken. Non-branch opcodes yield 0.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0]  i_ir,
  input  logic [FLAG_W-1:0] i_ccr,
  output logic              o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_ir)
      OP_BRA:  o_taken = 1'b1;
      OP_BMI:  o_taken =  i_ccr[CCR_N];
      OP_BPL:  o_taken = ~i_ccr[CCR_N];
      OP_BEQ:  o_taken =  i_ccr[CCR_Z];
      OP_BNE:  o_taken = ~i_ccr[CCR_Z];
      OP_BVS:  o_taken =  i_ccr[CCR_V];
      OP_BVC:  o_taken = ~i_ccr[CCR_V];
      OP_BCS:  o_taken =  i_ccr[CCR_C];
      OP_BCC:  o_taken = ~i_ccr[CCR_C];
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit CPU. Control word is registered
// alongside the state and forced to zero while Reset is held.
module control_unit
  import cpu_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [OPC_W-1:0]  IR,
  input  logic [FLAG_W-1:0] CCR_Result,
  output logic              IR_Load,
  output logic              MAR_Load,
  output logic              PC_Load,
  output logic              PC_Inc,
  output logic              A_Load,
  output logic              B_Load,
  output logic              CCR_Load,
  output logic [2:0]        ALU_Sel,
  output logic [1:0]        Bus1_Sel,
  output logic [1:0]        Bus2_Sel,
  output logic              write
);

  state_t r_state;
  state_t w_nextState;
  ctrl_t  r_ctrl;
  ctrl_t  w_ctrl;
  logic   w_taken;

  branch_cond u_branch_cond (
    .i_ir   (IR),
    .i_ccr  (CCR_Result),
    .o_taken(w_taken)
  );

  always_comb begin
    w_nextState = S_FETCH_0;
    case (r_state)
      S_FETCH_0:  w_nextState = S_FETCH_1;
      S_FETCH_1:  w_nextState = S_FETCH_2;
      S_FETCH_2:  w_nextState = S_DECODE_3;
      S_DECODE_3: begin
        case (IR)
          OP_LDA_IMM: w_nextState = S_LDA_IMM_4;
          OP_LDA_DIR: w_nextState = S_LDA_DIR_4;
          OP_LDB_IMM: w_nextState = S_LDB_IMM_4;
          OP_LDB_DIR: w_nextState = S_LDB_DIR_4;
          OP_STA_DIR: w_nextState = S_STA_DIR_4;
          OP_STB_DIR: w_nextState = S_STB_DIR_4;
          OP_ADD_AB:  w_nextState = S_ADD_4;
          OP_SUB_AB:  w_nextState = S_SUB_4;
          OP_AND_AB:  w_nextState = S_AND_4;
          OP_OR_AB:   w_nextState = S_OR_4;
          OP_NOT_A:   w_nextState = S_NOT_4;
          OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
          OP_BVS, OP_BVC, OP_BCS, OP_BCC:
            w_nextState = w_taken ? S_BRA_4 : S_BNT_4;
          default:    w_nextState = S_FETCH_0;
        endcase
      end
      S_LDA_IMM_4: w_nextState = S_LDA_IMM_5;
      S_LDA_IMM_5: w_nextState = S_LDA_IMM_6;
      S_LDA_DIR_4: w_nextState = S_LDA_DIR_5;
      S_LDA_DIR_5: w_nextState = S_LDA_DIR_6;
      S_LDA_DIR_6: w_nextState = S_LDA_DIR_7;
      S_LDA_DIR_7: w_nextState = S_LDA_DIR_8;
      S_LDB_IMM_4: w_nextState = S_LDB_IMM_5;
      S_LDB_IMM_5: w_nextState = S_LDB_IMM_6;
      S_LDB_DIR_4: w_nextState = S_LDB_DIR_5;
      S_LDB_DIR_5: w_nextState = S_LDB_DIR_6;
      S_LDB_DIR_6: w_nextState = S_LDB_DIR_7;
      S_LDB_DIR_7: w_nextState = S_LDB_DIR_8;
      S_STA_DIR_4: w_nextState = S_STA_DIR_5;
      S_STA_DIR_5: w_nextState = S_STA_DIR_6;
      S_STA_DIR_6: w_nextState = S_STA_DIR_7;
      S_STB_DIR_4: w_nextState = S_STB_DIR_5;
      S_STB_DIR_5: w_nextState = S_STB_DIR_6;
      S_STB_DIR_6: w_nextState = S_STB_DIR_7;
      S_BRA_4:     w_nextState = S_BRA_5;
      S_BRA_5:     w_nextState = S_BRA_6;
      default:     w_nextState = S_FETCH_0;
    endcase
  end

  // Registering decode(next) keeps outputs glitch-free while staying a pure function of state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_FETCH_0;
      r_ctrl  <= decode_ctrl(S_FETCH_0);
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= decode_ctrl(w_nextState);
    end
  end

  assign w_ctrl   = Reset ? '0 : r_ctrl;

  assign IR_Load  = w_ctrl.irLoad;
  assign MAR_Load = w_ctrl.marLoad;
  assign PC_Load  = w_ctrl.pcLoad;
  assign PC_Inc   = w_ctrl.pcInc;
  assign A_Load   = w_ctrl.aLoad;
  assign B_Load   = w_ctrl.bLoad;
  assign CCR_Load = w_ctrl.ccrLoad;
  assign ALU_Sel  = w_ctrl.aluSel;
  assign Bus1_Sel = w_ctrl.bus1Sel;
  assign Bus2_Sel = w_ctrl.bus2Sel;
  assign write    = w_ctrl.write;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle control word comparison
// against an instruction-level microcycle model, with randomized programs.
module tb_control_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] IR = 8'h00;
  logic [3:0] CCR_Result = 4'h0;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;
  logic [14:0] expQ[$];
  logic [7:0]  known[20] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                             8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                             8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

  control_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .IR        (IR),
    .CCR_Result(CCR_Result),
    .IR_Load   (IR_Load),
    .MAR_Load  (MAR_Load),
    .PC_Load   (PC_Load),
    .PC_Inc    (PC_Inc),
    .A_Load    (A_Load),
    .B_Load    (B_Load),
    .CCR_Load  (CCR_Load),
    .ALU_Sel   (ALU_Sel),
    .Bus1_Sel  (Bus1_Sel),
    .Bus2_Sel  (Bus2_Sel),
    .write     (write)
  );

  always #5 Clk = ~Clk;

  assign obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                ALU_Sel, Bus1_Sel, Bus2_Sel, write};

  // Build one control word: strobes, ALU select, bus selects, write.
  function automatic logic [14:0] cw(input bit ir, input bit mar, input bit pcl, input bit pci,
                                     input bit al, input bit bl, input bit ccrl,
                                     input logic [2:0] alu, input logic [1:0] b1,
                                     input logic [1:0] b2, input bit wr);
    return {ir, mar, pcl, pci, al, bl, ccrl, alu, b1, b2, wr};
  endfunction

  function automatic logic [14:0] vMarFromPc();
    return cw(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 0);
  endfunction

  function automatic logic [14:0] vPcInc();
    return cw(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0);
  endfunction

  function automatic bit isKnown(input logic [7:0] op);
    foreach (known[k]) if (known[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Branch rule: BRA always; 21..28 pair up per flag N,Z,V,C, odd offset tests set, even tests clear.
  function automatic bit branchTaken(input logic [7:0] op, input logic [3:0] ccr);
    int cond;
    if (op == 8'h20) return 1'b1;
    cond = int'(op) - 8'h21;
    return ccr[3 - cond / 2] == ((cond % 2) == 0);
  endfunction

  // Expected microcycle list of a whole instruction, starting at F0.
  task automatic modelInstr(input logic [7:0] op, input logic [3:0] ccr);
    logic [2:0] alu;
    expQ.delete();
    expQ.push_back(vMarFromPc());
    expQ.push_back(vPcInc());
    expQ.push_back(cw(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0));
    expQ.push_back(15'd0);
    if (op == 8'h86 || op == 8'h88) begin
      expQ.push_back(vMarFromPc());
      expQ.push_back(vPcInc());
      expQ.push_back(cw(0, 0, 0, 0, op == 8'h86, op == 8'h88, 0, 3'b000, 2'b00, 2'b10, 0));
    end else if (op == 8'h87 || op == 8'h89) begin
      expQ.push_back(vMarFromPc());
      expQ.push_back(vPcInc());
      expQ.push_back(cw(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0));
      expQ.push_back(15'd0);
      expQ.push_back(cw(0, 0, 0, 0, op == 8'h87, op == 8'h89, 0, 3'b000, 2'b00, 2'b10, 0));
    end else if (op == 8'h96 || op == 8'h97) begin
      expQ.push_back(vMarFromPc());
      expQ.push_back(vPcInc());
      expQ.push_back(cw(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0));
      expQ.push_back(cw(0, 0, 0, 0, 0, 0, 0, 3'b000, (op == 8'h96) ? 2'b01 : 2'b10, 2'b00, 1));
    end else if (op >= 8'h42 && op <= 8'h46) begin
      case (op)
        8'h42:   alu = 3'b000;
        8'h43:   alu = 3'b010;
        8'h44:   alu = 3'b011;
        8'h45:   alu = 3'b100;
        default: alu = 3'b111;
      endcase
      expQ.push_back(cw(0, 0, 0, 0, 1, 0, 1, alu, 2'b01, 2'b00, 0));
    end else if (op >= 8'h20 && op <= 8'h28) begin
      if (branchTaken(op, ccr)) begin
        expQ.push_back(vMarFromPc());
        expQ.push_back(15'd0);
        expQ.push_back(cw(0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0));
      end else begin
        expQ.push_back(vPcInc());
      end
    end
  endtask

  // Runs one instruction from F0; limit >= 0 stops after that many cycles (for mid-instruction reset).
  task automatic applyStimulus(input logic [7:0] op, input logic [3:0] ccr, input int limit,
                               input string name);
    int n;
    IR = op;
    CCR_Result = ccr;
    modelInstr(op, ccr);
    n = expQ.size();
    if (limit >= 0 && limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL %s op=%h ccr=%b cyc=%0d got=%b exp=%b", name, op, ccr, i, obs, expQ[i]);
      end
      checks++;
      if (PC_Load === 1'b1 && PC_Inc === 1'b1) begin
        errors++;
        $display("[TB] FAIL pc_conflict %s op=%h cyc=%0d got PC_Load=1 PC_Inc=1 exp not both", name, op, i);
      end
      @(negedge Clk);
    end
  endtask

  task automatic holdResetAndRelease(input string name);
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== 15'd0) begin
      errors++;
      $display("[TB] FAIL %s_immediate got=%b exp=%b", name, obs, 15'd0);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      checks++;
      if (obs !== 15'd0) begin
        errors++;
        $display("[TB] FAIL %s_held cyc=%0d got=%b exp=%b", name, c, obs, 15'd0);
      end
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (obs !== vMarFromPc()) begin
      errors++;
      $display("[TB] FAIL %s_release got=%b exp=%b", name, obs, vMarFromPc());
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    holdResetAndRelease("reset_init");
    applyStimulus(8'h87, 4'h0, 7, "lda_dir_partial");
    holdResetAndRelease("reset_mid_lda_dir");
    applyStimulus(8'h86, 4'h0, -1, "lda_imm_after_reset");
  endtask

  task automatic test_reset_mid_store();
    applyStimulus(8'h97, 4'($urandom), 7, "stb_dir_partial");
    checks++;
    if (write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stb_e7_write got=%b exp=1", write);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_under_reset got=%b exp=0", write);
    end
    holdResetAndRelease("reset_mid_stb_dir");
  endtask

  task automatic test_load_store();
    logic [7:0] ops[6] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97};
    foreach (ops[k]) applyStimulus(ops[k], 4'($urandom), -1, "load_store");
  endtask

  task automatic test_alu();
    for (int k = 0; k < 5; k++) applyStimulus(8'h42 + 8'(k), 4'($urandom), -1, "alu");
  endtask

  task automatic test_branch();
    applyStimulus(8'h23, 4'b0100, -1, "beq_taken");
    applyStimulus(8'h23, 4'b0000, -1, "beq_not_taken");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(8'h20 + 8'(k), 4'($urandom), -1, "branch_rand");
      applyStimulus(8'h20 + 8'(k), 4'($urandom), -1, "branch_rand");
    end
  endtask

  task automatic test_unknown();
    logic [7:0] op;
    applyStimulus(8'hFF, 4'($urandom), -1, "unknown_ff");
    for (int k = 0; k < 6; k++) begin
      op = 8'($urandom_range(0, 255));
      while (isKnown(op)) op = 8'($urandom_range(0, 255));
      applyStimulus(op, 4'($urandom), -1, "unknown_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] op;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 8) op = known[$urandom_range(0, 19)];
      else op = 8'($urandom_range(0, 255));
      applyStimulus(op, 4'($urandom), -1, "back_to_back");
    end
  endtask

  task automatic checkOutput();
    checks++;
    if (obs !== vMarFromPc()) begin
      errors++;
      $display("[TB] FAIL final_f0 got=%b exp=%b", obs, vMarFromPc());
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_alu();
    test_branch();
    test_unknown();
    test_reset_mid_store();
    test_back_to_back();
    checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
